// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch stage, the data-memory stage, the arbiter and the unified memory.
// The arbiter uses the slave view; the pipeline/memory side uses the master view.
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          fetch_hold;

  logic          dm_req;
  logic          dm_wen_n;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;

  logic          mem_en;
  logic          mem_wen_n;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_wen_n, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, fetch_hold,
           dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_wen_n, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_wen_n, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, fetch_hold,
           dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_wen_n, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and LW/SW accesses.
// Data wins by default; a run counter forces a fetch grant after DM_RUN_MAX data grants.
module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 16,
  parameter int MEM_LAT    = 2,
  parameter int DM_RUN_MAX = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int RW = $clog2(DM_RUN_MAX + 1);
  localparam logic [LW-1:0] LAT_LOAD = LW'(MEM_LAT - 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(DM_RUN_MAX);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_IF = 2'd1,
    ISSUE_DM = 2'd2,
    WAIT_RD  = 2'd3
  } stateT;

  stateT         state;
  stateT         nextState;
  logic [RW-1:0] runCnt;
  logic [LW-1:0] latCnt;
  logic [AW-1:0] latAddr;
  logic [DW-1:0] latWdata;
  logic          latWenN;
  logic          latIsIf;
  logic [DW-1:0] ifRdataQ;
  logic [DW-1:0] dmRdataQ;
  logic          ifRvalidQ;
  logic          dmRvalidQ;
  logic          ifWins;
  logic          dmWins;
  logic          capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // latCnt is loaded on the grant edge so mem_rdata is sampled on the
  // MEM_LAT-th edge after the one that raises mem_en.
  always_comb begin
    ifWins    = bus.if_req && (!bus.dm_req || (runCnt == RUN_MAX));
    dmWins    = bus.dm_req && !ifWins;
    capture   = 1'b0;
    nextState = state;
    case (state)
      IDLE: begin
        if (ifWins) begin
          nextState = ISSUE_IF;
        end else if (dmWins) begin
          nextState = ISSUE_DM;
        end
      end
      ISSUE_IF: begin
        if (latCnt == '0) begin
          capture   = 1'b1;
          nextState = IDLE;
        end else begin
          nextState = WAIT_RD;
        end
      end
      ISSUE_DM: begin
        if (!latWenN) begin
          nextState = IDLE;
        end else if (latCnt == '0) begin
          capture   = 1'b1;
          nextState = IDLE;
        end else begin
          nextState = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (latCnt == '0) begin
          capture   = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      runCnt    <= '0;
      latCnt    <= '0;
      latAddr   <= '0;
      latWdata  <= '0;
      latWenN   <= 1'b1;
      latIsIf   <= 1'b0;
      ifRdataQ  <= '0;
      dmRdataQ  <= '0;
      ifRvalidQ <= 1'b0;
      dmRvalidQ <= 1'b0;
    end else begin
      ifRvalidQ <= capture && latIsIf;
      dmRvalidQ <= capture && !latIsIf;
      if (capture && latIsIf) begin
        ifRdataQ <= bus.mem_rdata;
      end
      if (capture && !latIsIf) begin
        dmRdataQ <= bus.mem_rdata;
      end

      if (state == IDLE && ifWins) begin
        latAddr <= bus.if_addr;
        latWenN <= 1'b1;
        latIsIf <= 1'b1;
        latCnt  <= LAT_LOAD;
        runCnt  <= '0;
      end else if (state == IDLE && dmWins) begin
        latAddr  <= bus.dm_addr;
        latWdata <= bus.dm_wdata;
        latWenN  <= bus.dm_wen_n;
        latIsIf  <= 1'b0;
        latCnt   <= LAT_LOAD;
        // Only a data grant that actually overtakes a waiting fetch extends the run.
        if (!bus.if_req) begin
          runCnt <= '0;
        end else if (runCnt != RUN_MAX) begin
          runCnt <= runCnt + 1'b1;
        end
      end else if (state != IDLE && latCnt != '0) begin
        latCnt <= latCnt - 1'b1;
      end
    end
  end

  assign bus.if_gnt     = (state == ISSUE_IF);
  assign bus.dm_gnt     = (state == ISSUE_DM);
  assign bus.mem_en     = (state == ISSUE_IF) || (state == ISSUE_DM);
  assign bus.mem_wen_n  = (state == ISSUE_DM) ? latWenN : 1'b1;
  assign bus.mem_addr   = latAddr;
  assign bus.mem_wdata  = latWdata;
  assign bus.if_rvalid  = ifRvalidQ;
  assign bus.dm_rvalid  = dmRvalidQ;
  assign bus.if_rdata   = ifRdataQ;
  assign bus.dm_rdata   = dmRdataQ;
  assign bus.fetch_hold = bus.if_req && !ifRvalidQ;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one MEM_LAT=2 instance for most scenarios and a
// MEM_LAT=1 instance for the short-latency fetch run.
module tb_mem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(2), .DM_RUN_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .DM_RUN_MAX(4)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  // Memory contents: one marker word, everything else derived from the address.
  function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
    if (a == 8'h10) return 16'hBEEF;
    return {~a, a};
  endfunction

  always_comb bus.mem_rdata  = memWord(bus.mem_addr);
  always_comb bus1.mem_rdata = memWord(bus1.mem_addr);

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0]  ctrl;
    logic [31:0] data;
    rst_n = 1'b0;
    repeat (2) nextCycle();
    ctrl = {bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid, bus.mem_en, bus.mem_wen_n};
    checks++;
    if (ctrl !== 6'b000001) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrl, 6'b000001);
    end
    data = {bus.mem_addr, bus.mem_wdata};
    checks++;
    if (data[23:0] !== 24'h0) begin
      errors++;
      $display("[TB] FAIL reset_mem_bus: got %h expected %h", data[23:0], 24'h0);
    end
    data = {bus.if_rdata, bus.dm_rdata};
    checks++;
    if (data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_rdata: got %h expected %h", data, 32'h0);
    end
    rst_n = 1'b1;
    nextCycle();
    ctrl = {bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid, bus.mem_en, bus.mem_wen_n};
    checks++;
    if (ctrl !== 6'b000001) begin
      errors++;
      $display("[TB] FAIL reset_release_idle: got %b expected %b", ctrl, 6'b000001);
    end
  endtask

  task automatic test_single_lw();
    logic [3:0]  ctrl;
    logic [16:0] rv;
    bus.dm_req = 1'b1; bus.dm_wen_n = 1'b1; bus.dm_addr = 8'h10;
    nextCycle();
    ctrl = {bus.dm_gnt, bus.if_gnt, bus.mem_en, bus.mem_wen_n};
    checks++;
    if (ctrl !== 4'b1011) begin
      errors++;
      $display("[TB] FAIL lw_grant: got %b expected %b", ctrl, 4'b1011);
    end
    checks++;
    if (bus.mem_addr !== 8'h10) begin
      errors++;
      $display("[TB] FAIL lw_addr: got %h expected %h", bus.mem_addr, 8'h10);
    end
    bus.dm_req = 1'b0;
    nextCycle();
    ctrl = {bus.dm_gnt, bus.mem_en, bus.dm_rvalid, 1'b0};
    checks++;
    if (ctrl !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL lw_wait: got %b expected %b", ctrl, 4'b0000);
    end
    nextCycle();
    checks++;
    if (bus.dm_rvalid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lw_rvalid: got %b expected %b", bus.dm_rvalid, 1'b1);
    end
    checks++;
    if (bus.dm_rdata !== 16'hBEEF) begin
      errors++;
      $display("[TB] FAIL lw_rdata: got %h expected %h", bus.dm_rdata, 16'hBEEF);
    end
    nextCycle();
    rv = {bus.dm_rvalid, bus.dm_rdata};
    checks++;
    if (rv !== {1'b0, 16'hBEEF}) begin
      errors++;
      $display("[TB] FAIL lw_hold: got %h expected %h", rv, {1'b0, 16'hBEEF});
    end
  endtask

  task automatic test_single_sw();
    logic [34:0] issue;
    logic [3:0]  idle;
    logic [9:0]  nxt;
    logic [16:0] rv;
    bus.dm_req = 1'b1; bus.dm_wen_n = 1'b0; bus.dm_addr = 8'h22; bus.dm_wdata = 16'h1234;
    nextCycle();
    issue = {bus.dm_gnt, bus.mem_en, bus.mem_wen_n, bus.mem_addr, bus.mem_wdata};
    checks++;
    if (issue !== {1'b1, 1'b1, 1'b0, 8'h22, 16'h1234}) begin
      errors++;
      $display("[TB] FAIL sw_issue: got %h expected %h", issue, {1'b1, 1'b1, 1'b0, 8'h22, 16'h1234});
    end
    bus.dm_req = 1'b0; bus.dm_wen_n = 1'b1;
    nextCycle();
    idle = {bus.dm_gnt, bus.mem_en, bus.mem_wen_n, bus.dm_rvalid};
    checks++;
    if (idle !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL sw_idle: got %b expected %b", idle, 4'b0010);
    end
    bus.dm_req = 1'b1; bus.dm_addr = 8'h30;
    nextCycle();
    nxt = {bus.dm_gnt, bus.mem_wen_n, bus.mem_addr};
    checks++;
    if (nxt !== {1'b1, 1'b1, 8'h30}) begin
      errors++;
      $display("[TB] FAIL sw_next_grant: got %h expected %h", nxt, {1'b1, 1'b1, 8'h30});
    end
    bus.dm_req = 1'b0;
    repeat (2) nextCycle();
    rv = {bus.dm_rvalid, bus.dm_rdata};
    checks++;
    if (rv !== {1'b1, 16'hCF30}) begin
      errors++;
      $display("[TB] FAIL sw_next_rdata: got %h expected %h", rv, {1'b1, 16'hCF30});
    end
    nextCycle();
  endtask

  task automatic test_simultaneous();
    logic [4:0] exp [7];
    logic [4:0] got;
    exp = '{5'b00001, 5'b10001, 5'b00001, 5'b00101, 5'b01001, 5'b00001, 5'b00010};
    bus.if_req = 1'b1; bus.if_addr = 8'h40;
    bus.dm_req = 1'b1; bus.dm_wen_n = 1'b1; bus.dm_addr = 8'h10;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) #1;
      else nextCycle();
      got = {bus.dm_gnt, bus.if_gnt, bus.dm_rvalid, bus.if_rvalid, bus.fetch_hold};
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("[TB] FAIL sim_cycle%0d {dm_gnt,if_gnt,dm_rv,if_rv,hold}: got %b expected %b", i, got, exp[i]);
      end
      if (i == 1) bus.dm_req = 1'b0;
      if (i == 6) bus.if_req = 1'b0;
    end
    checks++;
    if (bus.if_rdata !== 16'hBF40) begin
      errors++;
      $display("[TB] FAIL sim_if_rdata: got %h expected %h", bus.if_rdata, 16'hBF40);
    end
    checks++;
    if (bus.dm_rdata !== 16'hBEEF) begin
      errors++;
      $display("[TB] FAIL sim_dm_rdata: got %h expected %h", bus.dm_rdata, 16'hBEEF);
    end
    nextCycle();
  endtask

  task automatic test_starvation();
    logic [9:0] seq;
    int nGrants;
    int firstCyc;
    int lastCyc;
    seq = '0; nGrants = 0; firstCyc = 0; lastCyc = 0;
    bus.if_req = 1'b1; bus.if_addr = 8'h50;
    bus.dm_req = 1'b1; bus.dm_wen_n = 1'b1; bus.dm_addr = 8'h60;
    for (int cyc = 0; cyc < 60 && nGrants < 10; cyc++) begin
      nextCycle();
      if (bus.dm_gnt || bus.if_gnt) begin
        seq[nGrants] = bus.if_gnt;
        if (nGrants == 0) firstCyc = cyc;
        lastCyc = cyc;
        nGrants++;
      end
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    checks++;
    if (nGrants !== 10) begin
      errors++;
      $display("[TB] FAIL starve_grant_count: got %0d expected %0d", nGrants, 10);
    end
    checks++;
    if (seq !== 10'b1000010000) begin
      errors++;
      $display("[TB] FAIL starve_order (bit=1 is IF): got %b expected %b", seq, 10'b1000010000);
    end
    checks++;
    if (lastCyc - firstCyc !== 27) begin
      errors++;
      $display("[TB] FAIL starve_spacing: got %0d expected %0d", lastCyc - firstCyc, 27);
    end
    repeat (4) nextCycle();
  endtask

  task automatic test_reset_mid_read();
    logic [5:0]  ctrl;
    logic [55:0] data;
    logic [9:0]  gnt;
    logic [17:0] rv;
    int rvCount;
    rvCount = 0;
    bus.dm_req = 1'b1; bus.dm_wen_n = 1'b1; bus.dm_addr = 8'h70;
    nextCycle();
    checks++;
    if (bus.dm_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_mid_grant: got %b expected %b", bus.dm_gnt, 1'b1);
    end
    bus.dm_req = 1'b0;
    nextCycle();
    rst_n = 1'b0;
    #1;
    ctrl = {bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid, bus.mem_en, bus.mem_wen_n};
    checks++;
    if (ctrl !== 6'b000001) begin
      errors++;
      $display("[TB] FAIL rst_mid_ctrl: got %b expected %b", ctrl, 6'b000001);
    end
    data = {bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata};
    checks++;
    if (data !== 56'h0) begin
      errors++;
      $display("[TB] FAIL rst_mid_data: got %h expected %h", data, 56'h0);
    end
    repeat (2) begin
      nextCycle();
      rvCount += int'(bus.dm_rvalid) + int'(bus.if_rvalid);
    end
    rst_n = 1'b1;
    repeat (3) begin
      nextCycle();
      rvCount += int'(bus.dm_rvalid) + int'(bus.if_rvalid);
    end
    checks++;
    if (rvCount !== 0) begin
      errors++;
      $display("[TB] FAIL rst_mid_no_rvalid: got %0d expected %0d", rvCount, 0);
    end
    bus.if_req = 1'b1; bus.if_addr = 8'h10;
    nextCycle();
    gnt = {bus.if_gnt, bus.mem_en, bus.mem_addr};
    checks++;
    if (gnt !== {1'b1, 1'b1, 8'h10}) begin
      errors++;
      $display("[TB] FAIL rst_fresh_grant: got %h expected %h", gnt, {1'b1, 1'b1, 8'h10});
    end
    repeat (2) nextCycle();
    rv = {bus.if_rvalid, bus.fetch_hold, bus.if_rdata};
    checks++;
    if (rv !== {1'b1, 1'b0, 16'hBEEF}) begin
      errors++;
      $display("[TB] FAIL rst_fresh_rvalid: got %h expected %h", rv, {1'b1, 1'b0, 16'hBEEF});
    end
    bus.if_req = 1'b0;
    nextCycle();
  endtask

  task automatic test_memlat1();
    logic [2:0]    exp [8];
    logic [2:0]    got;
    logic [AW-1:0] grantAddr;
    exp = '{3'b001, 3'b101, 3'b010, 3'b101, 3'b010, 3'b101, 3'b010, 3'b000};
    grantAddr = '0;
    bus1.if_req = 1'b1; bus1.if_addr = 8'h01;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) #1;
      else nextCycle();
      got = {bus1.if_gnt, bus1.if_rvalid, bus1.fetch_hold};
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("[TB] FAIL lat1_cycle%0d {if_gnt,if_rv,hold}: got %b expected %b", i, got, exp[i]);
      end
      if (i == 2 || i == 4 || i == 6) begin
        checks++;
        if (bus1.if_rdata !== memWord(grantAddr)) begin
          errors++;
          $display("[TB] FAIL lat1_rdata_cycle%0d: got %h expected %h", i, bus1.if_rdata, memWord(grantAddr));
        end
      end
      if (i == 1 || i == 3 || i == 5) begin
        grantAddr    = bus1.if_addr;
        bus1.if_addr = bus1.if_addr + 8'h01;
      end
      if (i == 5) bus1.if_req = 1'b0;
    end
  endtask

  initial begin
    bus.if_req = 1'b0;  bus.if_addr = '0;  bus.dm_req = 1'b0;  bus.dm_wen_n = 1'b1;
    bus.dm_addr = '0;   bus.dm_wdata = '0;
    bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.dm_req = 1'b0; bus1.dm_wen_n = 1'b1;
    bus1.dm_addr = '0;  bus1.dm_wdata = '0;
    rst_n = 1'b0;
    #1;
    test_reset();
    test_single_lw();
    test_single_sw();
    test_simultaneous();
    test_starvation();
    test_reset_mid_read();
    test_memlat1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
